// File: rtl/pc_stack.sv
// pc_stack: program counter with relative branch and hardware return-address stack
module pc_stack #(
  parameter int P_ADDRESS_WIDTH = 16,
  parameter int P_STACK_DEPTH = 8,
  parameter logic [P_ADDRESS_WIDTH-1:0] P_RESET_ADDRESS = '0
) (
  input  logic                                I_CLK,
  input  logic                                I_RESET,
  input  logic                                I_ENABLE,
  input  logic [2:0]                          I_OP,
  input  logic [P_ADDRESS_WIDTH-1:0]          I_ADDRESS,
  output logic [P_ADDRESS_WIDTH-1:0]          O_ADDRESS,
  output logic [$clog2(P_STACK_DEPTH):0]      O_STACK_COUNT,
  output logic                                O_STACK_EMPTY,
  output logic                                O_STACK_FULL,
  output logic                                O_OVERFLOW,
  output logic                                O_UNDERFLOW,
  output logic                                O_ILLEGAL
);
  localparam int PW = $clog2(P_STACK_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_INC = 3'd1;
  localparam logic [2:0] OP_JUMP = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RETURN = 3'd5;

  logic [P_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       ovf_q, ovf_d;
  logic                       unf_q, unf_d;
  logic                       ill_q, ill_d;
  logic [P_ADDRESS_WIDTH-1:0] entry_q [P_STACK_DEPTH];
  logic                       push;
  logic                       full;
  logic                       empty;
  logic [PW-1:0]              top_idx;
  logic [PW-1:0]              push_idx;
  logic [CW-1:0]              count_dec;
  logic [P_ADDRESS_WIDTH-1:0] ret_addr;

  assign full = count_q == CW'(P_STACK_DEPTH);
  assign empty = count_q == '0;
  assign count_dec = count_q - CW'(1);
  assign top_idx = count_dec[PW-1:0];
  assign push_idx = count_q[PW-1:0];
  assign ret_addr = addr_q + P_ADDRESS_WIDTH'(1);

  // decode one operation per enabled cycle; faults set sticky flags and otherwise hold
  always_comb begin
    addr_d = addr_q;
    count_d = count_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    ill_d = ill_q;
    push = 1'b0;
    if (I_ENABLE) begin
      case (I_OP)
        OP_HOLD: ;
        OP_INC: addr_d = ret_addr;
        OP_JUMP: addr_d = I_ADDRESS;
        OP_BRANCH: addr_d = addr_q + I_ADDRESS;
        OP_CALL: begin
          if (full) ovf_d = 1'b1;
          else begin
            push = 1'b1;
            addr_d = I_ADDRESS;
            count_d = count_q + CW'(1);
          end
        end
        OP_RETURN: begin
          if (empty) unf_d = 1'b1;
          else begin
            addr_d = entry_q[top_idx];
            count_d = count_dec;
          end
        end
        default: ill_d = 1'b1;
      endcase
    end
  end

  // pc, stack pointer and sticky flags; reset overrides enable
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      addr_q <= P_RESET_ADDRESS;
      count_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      ill_q <= ill_d;
    end
  end

  // stack storage is never cleared; only the pointer defines valid entries
  always_ff @(posedge I_CLK) begin
    if (!I_RESET && push) entry_q[push_idx] <= ret_addr;
  end

  assign O_ADDRESS = addr_q;
  assign O_STACK_COUNT = count_q;
  assign O_STACK_EMPTY = empty;
  assign O_STACK_FULL = full;
  assign O_OVERFLOW = ovf_q;
  assign O_UNDERFLOW = unf_q;
  assign O_ILLEGAL = ill_q;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed and random checks of pc_stack against a queue-based model
module tb_pc_stack;
  localparam int DEPTH = 8;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] a = 16'h0;
  logic [15:0] o_addr;
  logic [3:0]  o_count;
  logic        o_empty, o_full, o_ovf, o_unf, o_ill;
  int checks = 0;
  int failures = 0;
  logic [15:0] m_pc = 16'h0;
  logic [15:0] m_stack[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0, m_ill = 1'b0;

  pc_stack #(.P_ADDRESS_WIDTH(16), .P_STACK_DEPTH(DEPTH), .P_RESET_ADDRESS(16'h0)) dut (
    .I_CLK(clk), .I_RESET(rst), .I_ENABLE(en), .I_OP(op), .I_ADDRESS(a),
    .O_ADDRESS(o_addr), .O_STACK_COUNT(o_count), .O_STACK_EMPTY(o_empty),
    .O_STACK_FULL(o_full), .O_OVERFLOW(o_ovf), .O_UNDERFLOW(o_unf), .O_ILLEGAL(o_ill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"}, 32'(o_addr), 32'(m_pc));
    chk({tag, ".count"}, 32'(o_count), 32'(m_stack.size()));
    chk({tag, ".empty"}, 32'(o_empty), 32'(m_stack.size() == 0));
    chk({tag, ".full"}, 32'(o_full), 32'(m_stack.size() == DEPTH));
    chk({tag, ".ovf"}, 32'(o_ovf), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(o_unf), 32'(m_unf));
    chk({tag, ".ill"}, 32'(o_ill), 32'(m_ill));
  endtask

  task automatic model(input logic r, input logic e, input logic [2:0] o, input logic [15:0] x);
    if (r) begin
      m_pc = 16'h0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_ill = 1'b0;
    end else if (e) begin
      case (o)
        3'd1: m_pc = m_pc + 16'd1;
        3'd2: m_pc = x;
        3'd3: m_pc = m_pc + x;
        3'd4: if (m_stack.size() == DEPTH) m_ovf = 1'b1;
              else begin m_stack.push_back(m_pc + 16'd1); m_pc = x; end
        3'd5: if (m_stack.size() == 0) m_unf = 1'b1;
              else m_pc = m_stack.pop_back();
        3'd6, 3'd7: m_ill = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] o, input logic [15:0] x);
    rst = r;
    en = e;
    op = o;
    a = x;
    @(posedge clk);
    #1;
    model(r, e, o, x);
    check_all(tag);
  endtask

  initial begin
    step("reset", 1, 0, 3'd0, 16'h0);
    chk("reset.addr0", 32'(o_addr), 32'h0);
    chk("reset.empty1", 32'(o_empty), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      step("inc", 0, 1, 3'd1, 16'h0);
      chk("inc.value", 32'(o_addr), 32'(i));
    end
    step("jump10", 0, 1, 3'd2, 16'h0010);
    step("branch_neg", 0, 1, 3'd3, 16'hFFFC);
    chk("branch_neg.value", 32'(o_addr), 32'h000C);
    step("jumpffff", 0, 1, 3'd2, 16'hFFFF);
    step("inc_wrap", 0, 1, 3'd1, 16'h0);
    chk("inc_wrap.value", 32'(o_addr), 32'h0);
    step("jump20", 0, 1, 3'd2, 16'h0020);
    step("call100", 0, 1, 3'd4, 16'h0100);
    step("call200", 0, 1, 3'd4, 16'h0200);
    chk("call200.count", 32'(o_count), 32'd2);
    step("ret1", 0, 1, 3'd5, 16'h0);
    chk("ret1.value", 32'(o_addr), 32'h0101);
    step("ret2", 0, 1, 3'd5, 16'h0);
    chk("ret2.value", 32'(o_addr), 32'h0021);
    for (int i = 0; i < 9; i++) step("call_fill", 0, 1, 3'd4, 16'h1000 + 16'(i * 16));
    chk("fill.full", 32'(o_full), 32'h1);
    chk("fill.ovf", 32'(o_ovf), 32'h1);
    chk("fill.addr_held", 32'(o_addr), 32'h1070);
    step("ret_after_ovf", 0, 1, 3'd5, 16'h0);
    chk("ret_after_ovf.value", 32'(o_addr), 32'h1061);
    for (int i = 0; i < 7; i++) step("drain", 0, 1, 3'd5, 16'h0);
    step("ret_empty", 0, 1, 3'd5, 16'h0);
    step("hold_unf", 0, 1, 3'd0, 16'h0);
    chk("unf.sticky", 32'(o_unf), 32'h1);
    step("illegal6", 0, 1, 3'd6, 16'h1234);
    step("illegal7", 0, 1, 3'd7, 16'h1234);
    step("reset_flags", 1, 1, 3'd0, 16'h0);
    chk("reset_flags.all", 32'({o_ovf, o_unf, o_ill}), 32'h0);
    step("jump_pre", 0, 1, 3'd2, 16'h0ABC);
    for (int i = 0; i < 5; i++) step("disabled_call", 0, 0, 3'd4, 16'h5555);
    for (int i = 0; i < 3; i++) step("push3", 0, 1, 3'd4, 16'h0200 + 16'(i));
    step("reset_disabled", 1, 0, 3'd4, 16'h0);
    chk("reset_disabled.count", 32'(o_count), 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic [2:0] ro;
      logic [15:0] ra;
      ro = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
      ra = 16'($urandom);
      step("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, ro, ra);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
